// File: rtl/csc_pkg.sv
// Shared types and default timing constants for the 65816 bus cycle sequencer.
package csc_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_HIGH = 2'd1,
        S_WAIT = 2'd2
    } csc_state_e;

    typedef enum logic [1:0] {
        REG_RAM = 2'd0,
        REG_ROM = 2'd1,
        REG_IO  = 2'd2
    } csc_region_e;

    localparam int unsigned DEF_LOW_TICKS    = 4;
    localparam int unsigned DEF_HIGH_TICKS   = 4;
    localparam int unsigned DEF_ROM_WAIT     = 2;
    localparam int unsigned DEF_IO_WAIT      = 4;
    localparam int unsigned DEF_CNT_W        = 4;
    localparam int unsigned DEF_WAIT_TIMEOUT = 15;

    // ROM wins over I/O; cycles with no valid address never stretch.
    function automatic csc_region_e region_of(input logic rom_sel, input logic io_sel,
                                              input logic valid);
        csc_region_e r;
        if (!valid)       r = REG_RAM;
        else if (rom_sel) r = REG_ROM;
        else if (io_sel)  r = REG_IO;
        else              r = REG_RAM;
        return r;
    endfunction

endpackage

// File: rtl/csc_phase_counter.sv
// Phase counter: clears on state entry, counts up otherwise, flags terminal count.
module csc_phase_counter
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] tc_val,
    output logic [CNT_W-1:0] cnt,
    output logic             tc_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin : cnt_next
        cnt_d = clr ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin : cnt_reg
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign tc_c = (cnt_q == tc_val);

endmodule

// File: rtl/bus_cycle_sequencer.sv
// 65816 bus cycle sequencer: PHI2 generation, bank latch, per-region wait states, RDB/WRB timing.
// Optional external I/O wait with timeout when CSC_EXT_WAIT_EN is defined.
module bus_cycle_sequencer
    import csc_pkg::*;
#(
    parameter int unsigned LOW_TICKS    = DEF_LOW_TICKS,
    parameter int unsigned HIGH_TICKS   = DEF_HIGH_TICKS,
    parameter int unsigned ROM_WAIT     = DEF_ROM_WAIT,
    parameter int unsigned IO_WAIT      = DEF_IO_WAIT,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
    input  logic       SYSCLK,
    input  logic       RESETB,
    input  logic [7:0] DB,
    input  logic       RWB,
    input  logic       VDA,
    input  logic       VPA,
    input  logic       ROM_SEL,
    input  logic       IO_SEL,
`ifdef CSC_EXT_WAIT_EN
    input  logic       EXTWAITB,
    output logic       BUS_TIMEOUT,
`endif
    output logic       PHI2,
    output logic [7:0] BA,
    output logic       RDB,
    output logic       WRB,
    output logic       CYCLE_END
);

    localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    if (LOW_TICKS < 2 || HIGH_TICKS < 2 || WAIT_TIMEOUT < 1 ||
        LOW_TICKS > CNT_MAX || HIGH_TICKS + ROM_WAIT > CNT_MAX ||
        HIGH_TICKS + IO_WAIT > CNT_MAX || WAIT_TIMEOUT > CNT_MAX) begin : g_param_check
        $error("bus_cycle_sequencer: tick parameters illegal or exceed CNT_W");
    end

    csc_state_e       state_q, state_d;
    logic             phi2_q, phi2_d;
    logic [7:0]       ba_q, ba_d;
    logic             rdb_q, rdb_d;
    logic             wrb_q, wrb_d;
    logic             cycle_end_q, cycle_end_d;
    logic [CNT_W-1:0] len_q, len_d;
`ifdef CSC_EXT_WAIT_EN
    logic             io_lat_q, io_lat_d;
    logic             bus_timeout_q, bus_timeout_d;
`endif

    logic [CNT_W-1:0] cnt;
    logic             tc_c;
    logic             clr_c;
    logic [CNT_W-1:0] tc_val_c;
    logic [CNT_W-1:0] len_new_c;
    logic [CNT_W-1:0] len_eff_c;
    logic             pre_last_c;
    logic             valid_c;
    logic             rd_c;
    logic             wr_c;
    csc_region_e      region_c;
    int unsigned      extra_c;

    assign valid_c  = VDA | VPA;
    assign rd_c     = RWB & valid_c;
    assign wr_c     = ~RWB & valid_c;
    assign region_c = region_of(ROM_SEL, IO_SEL, valid_c);

    // High-phase length is known combinationally on the entry cycle, registered after it.
    always_comb begin : len_sel
        extra_c = 0;
        case (region_c)
            REG_ROM: extra_c = ROM_WAIT;
            REG_IO:  extra_c = IO_WAIT;
            default: extra_c = 0;
        endcase
        len_new_c  = CNT_W'(HIGH_TICKS + extra_c);
        len_eff_c  = (cnt == '0) ? len_new_c : len_q;
        pre_last_c = ((CNT_W+1)'(cnt) + (CNT_W+1)'(2)) == (CNT_W+1)'(len_eff_c);
        case (state_q)
            S_HIGH:  tc_val_c = len_eff_c - CNT_W'(1);
            S_WAIT:  tc_val_c = CNT_W'(WAIT_TIMEOUT - 1);
            default: tc_val_c = CNT_W'(LOW_TICKS - 1);
        endcase
    end

    csc_phase_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (SYSCLK),
        .rst_n  (RESETB),
        .clr    (clr_c),
        .tc_val (tc_val_c),
        .cnt    (cnt),
        .tc_c   (tc_c)
    );

    assign clr_c = (state_d != state_q);

    always_comb begin : fsm_comb
        state_d     = state_q;
        phi2_d      = phi2_q;
        ba_d        = ba_q;
        rdb_d       = 1'b1;
        wrb_d       = 1'b1;
        cycle_end_d = 1'b0;
        len_d       = len_q;
`ifdef CSC_EXT_WAIT_EN
        io_lat_d      = io_lat_q;
        bus_timeout_d = bus_timeout_q;
`endif
        case (state_q)
            S_LOW: begin
                phi2_d = 1'b0;
                if (tc_c) begin
                    ba_d    = DB;
                    phi2_d  = 1'b1;
                    rdb_d   = ~rd_c;
                    wrb_d   = ~wr_c;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                rdb_d = ~rd_c;
                // Write strobe releases one cycle early to give data hold before PHI2 falls.
                wrb_d = ~wr_c | pre_last_c;
                if (cnt == '0) begin
                    len_d = len_new_c;
`ifdef CSC_EXT_WAIT_EN
                    io_lat_d = (region_c == REG_IO);
`endif
                end
                if (tc_c) begin
                    phi2_d      = 1'b0;
                    rdb_d       = 1'b1;
                    wrb_d       = 1'b1;
                    cycle_end_d = 1'b1;
                    state_d     = S_LOW;
`ifdef CSC_EXT_WAIT_EN
                    if (io_lat_q && !EXTWAITB) begin
                        phi2_d      = 1'b1;
                        rdb_d       = ~rd_c;
                        cycle_end_d = 1'b0;
                        state_d     = S_WAIT;
                    end
`endif
                end
            end
`ifdef CSC_EXT_WAIT_EN
            S_WAIT: begin
                rdb_d = ~rd_c;
                if (EXTWAITB || tc_c) begin
                    phi2_d      = 1'b0;
                    rdb_d       = 1'b1;
                    cycle_end_d = 1'b1;
                    state_d     = S_LOW;
                    if (!EXTWAITB) bus_timeout_d = 1'b1;
                end
            end
`endif
            default: begin
                phi2_d  = 1'b0;
                state_d = S_LOW;
            end
        endcase
    end

    always_ff @(posedge SYSCLK or negedge RESETB) begin : state_reg
        if (!RESETB) begin
            state_q     <= S_LOW;
            phi2_q      <= 1'b0;
            ba_q        <= 8'h00;
            rdb_q       <= 1'b1;
            wrb_q       <= 1'b1;
            cycle_end_q <= 1'b0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            phi2_q      <= phi2_d;
            ba_q        <= ba_d;
            rdb_q       <= rdb_d;
            wrb_q       <= wrb_d;
            cycle_end_q <= cycle_end_d;
            len_q       <= len_d;
        end
    end

`ifdef CSC_EXT_WAIT_EN
    always_ff @(posedge SYSCLK or negedge RESETB) begin : ext_wait_reg
        if (!RESETB) begin
            io_lat_q      <= 1'b0;
            bus_timeout_q <= 1'b0;
        end else begin
            io_lat_q      <= io_lat_d;
            bus_timeout_q <= bus_timeout_d;
        end
    end

    assign BUS_TIMEOUT = bus_timeout_q;
`endif

    assign PHI2      = phi2_q;
    assign BA        = ba_q;
    assign RDB       = rdb_q;
    assign WRB       = wrb_q;
    assign CYCLE_END = cycle_end_q;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed self-checking bench for bus_cycle_sequencer; ext-wait scenario built when CSC_EXT_WAIT_EN is defined.
module tb_bus_cycle_sequencer;

    logic       sysclk = 1'b0;
    logic       resetb = 1'b0;
    logic [7:0] db = 8'h00;
    logic       rwb = 1'b1;
    logic       vda = 1'b1;
    logic       vpa = 1'b0;
    logic       rom_sel = 1'b0;
    logic       io_sel = 1'b0;
    logic       phi2;
    logic [7:0] ba;
    logic       rdb;
    logic       wrb;
    logic       cycle_end;
`ifdef CSC_EXT_WAIT_EN
    logic       extwaitb = 1'b1;
    logic       bus_timeout;
`endif

    int vectors = 0;
    int miscompares = 0;

    int         lo_n, hi_n, rdl_n, wrl_n, ce_n;
    logic       last_wrb;
    logic [7:0] ba_rise;

    bus_cycle_sequencer dut (
        .SYSCLK      (sysclk),
        .RESETB      (resetb),
        .DB          (db),
        .RWB         (rwb),
        .VDA         (vda),
        .VPA         (vpa),
        .ROM_SEL     (rom_sel),
        .IO_SEL      (io_sel),
`ifdef CSC_EXT_WAIT_EN
        .EXTWAITB    (extwaitb),
        .BUS_TIMEOUT (bus_timeout),
`endif
        .PHI2        (phi2),
        .BA          (ba),
        .RDB         (rdb),
        .WRB         (wrb),
        .CYCLE_END   (cycle_end)
    );

    always #5 sysclk = ~sysclk;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual running, required done");
        $fatal(1);
    end

    // Called on the first PHI2-low sample of a bus cycle; returns on the first low sample of the next.
    task automatic run_cycle(input logic [7:0] db_v, input logic rwb_v, input logic vda_v,
                             input logic vpa_v, input logic rom_v, input logic io_v);
        db = db_v; rwb = rwb_v; vda = vda_v; vpa = vpa_v; rom_sel = rom_v; io_sel = io_v;
        lo_n = 1; hi_n = 0; rdl_n = 0; wrl_n = 0; ce_n = 0; last_wrb = 1'b0;
        while (phi2 === 1'b0 && lo_n < 64) begin
            @(negedge sysclk);
            if (phi2 === 1'b0) lo_n++;
        end
        ba_rise = ba;
        while (phi2 === 1'b1 && hi_n < 64) begin
            hi_n++;
            if (rdb === 1'b0) rdl_n++;
            if (wrb === 1'b0) wrl_n++;
            if (cycle_end === 1'b1) ce_n++;
            last_wrb = wrb;
            @(negedge sysclk);
        end
        if (cycle_end === 1'b1) ce_n++;
        vectors++;
        if (lo_n >= 64 || hi_n >= 64) begin
            miscompares++;
            $display("FAIL cycle_bound: lo=%0d hi=%0d, required both below 64", lo_n, hi_n);
        end
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        while (phi2 === 1'b0 && n < 64) begin
            @(negedge sysclk);
            n++;
        end
    endtask

    task automatic wait_fall();
        int n = 0;
        while (phi2 === 1'b1 && n < 64) begin
            @(negedge sysclk);
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        resetb = 1'b0; db = 8'h00; rwb = 1'b1; vda = 1'b1; vpa = 1'b0; rom_sel = 1'b0; io_sel = 1'b0;
        repeat (3) @(negedge sysclk);
        vectors++; if (phi2 !== 1'b0) begin miscompares++; $display("FAIL rst_phi2: got %b, required 0", phi2); end
        vectors++; if (rdb !== 1'b1) begin miscompares++; $display("FAIL rst_rdb: got %b, required 1", rdb); end
        vectors++; if (wrb !== 1'b1) begin miscompares++; $display("FAIL rst_wrb: got %b, required 1", wrb); end
        vectors++; if (ba !== 8'h00) begin miscompares++; $display("FAIL rst_ba: got %h, required 00", ba); end
        vectors++; if (cycle_end !== 1'b0) begin miscompares++; $display("FAIL rst_cycle_end: got %b, required 0", cycle_end); end
        resetb = 1'b1;
        wait_rise(n);
        vectors++; if (n != 4) begin miscompares++; $display("FAIL rst_first_rise: got %0d, required 4", n); end
        wait_fall();
    endtask

    task automatic test_ram_read();
        run_cycle(8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++; if (ba_rise !== 8'h12) begin miscompares++; $display("FAIL ram_ba: got %h, required 12", ba_rise); end
        vectors++; if (lo_n != 4) begin miscompares++; $display("FAIL ram_low: got %0d, required 4", lo_n); end
        vectors++; if (rdl_n != 4) begin miscompares++; $display("FAIL ram_rdb_low: got %0d, required 4", rdl_n); end
        vectors++; if (wrl_n != 0) begin miscompares++; $display("FAIL ram_wrb_low: got %0d, required 0", wrl_n); end
        vectors++; if (lo_n + hi_n != 8) begin miscompares++; $display("FAIL ram_period: got %0d, required 8", lo_n + hi_n); end
        vectors++; if (ce_n != 1) begin miscompares++; $display("FAIL ram_cycle_end: got %0d, required 1", ce_n); end
        vectors++; if (rdb !== 1'b1) begin miscompares++; $display("FAIL ram_rdb_after: got %b, required 1", rdb); end
    endtask

    task automatic test_wait_states();
        run_cycle(8'h34, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        vectors++; if (hi_n != 6) begin miscompares++; $display("FAIL rom_high: got %0d, required 6", hi_n); end
        vectors++; if (lo_n + hi_n != 10) begin miscompares++; $display("FAIL rom_period: got %0d, required 10", lo_n + hi_n); end
        vectors++; if (rdl_n != 6) begin miscompares++; $display("FAIL rom_rdb_low: got %0d, required 6", rdl_n); end
        vectors++; if (ba_rise !== 8'h34) begin miscompares++; $display("FAIL rom_ba: got %h, required 34", ba_rise); end
        run_cycle(8'h56, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        vectors++; if (hi_n != 8) begin miscompares++; $display("FAIL io_high: got %0d, required 8", hi_n); end
        vectors++; if (wrl_n != 7) begin miscompares++; $display("FAIL io_wrb_low: got %0d, required 7", wrl_n); end
        vectors++; if (last_wrb !== 1'b1) begin miscompares++; $display("FAIL io_wrb_hold: got %b, required 1", last_wrb); end
        vectors++; if (rdl_n != 0) begin miscompares++; $display("FAIL io_rdb_low: got %0d, required 0", rdl_n); end
        vectors++; if (lo_n + hi_n != 12) begin miscompares++; $display("FAIL io_period: got %0d, required 12", lo_n + hi_n); end
        run_cycle(8'h9F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        vectors++; if (hi_n != 6) begin miscompares++; $display("FAIL rom_priority_high: got %0d, required 6", hi_n); end
    endtask

    task automatic test_invalid_cycle();
        run_cycle(8'h78, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++; if (hi_n != 4) begin miscompares++; $display("FAIL inv_rd_high: got %0d, required 4", hi_n); end
        vectors++; if (rdl_n != 0) begin miscompares++; $display("FAIL inv_rd_rdb: got %0d, required 0", rdl_n); end
        run_cycle(8'h79, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++; if (hi_n != 4) begin miscompares++; $display("FAIL inv_wr_high: got %0d, required 4", hi_n); end
        vectors++; if (wrl_n != 0) begin miscompares++; $display("FAIL inv_wr_wrb: got %0d, required 0", wrl_n); end
        vectors++; if (ce_n != 1) begin miscompares++; $display("FAIL inv_cycle_end: got %0d, required 1", ce_n); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat [3];
        pat[0] = 8'h9A; pat[1] = 8'hBC; pat[2] = 8'hDE;
        for (int i = 0; i < 3; i++) begin
            run_cycle(pat[i], 1'(i % 2), 1'b1, 1'b1, 1'b0, 1'b0);
            vectors++; if (ba_rise !== pat[i]) begin miscompares++; $display("FAIL b2b_ba[%0d]: got %h, required %h", i, ba_rise, pat[i]); end
            vectors++; if (lo_n + hi_n != 8) begin miscompares++; $display("FAIL b2b_period[%0d]: got %0d, required 8", i, lo_n + hi_n); end
        end
    endtask

    task automatic test_reset_mid_cycle();
        int n;
        db = 8'hA5; rwb = 1'b0; vda = 1'b1; vpa = 1'b0; rom_sel = 1'b0; io_sel = 1'b0;
        wait_rise(n);
        @(negedge sysclk);
        vectors++; if (wrb !== 1'b0 || ba !== 8'hA5) begin miscompares++; $display("FAIL mid_pre: wrb=%b ba=%h, required 0 and a5", wrb, ba); end
        #2 resetb = 1'b0;
        #1;
        vectors++; if (phi2 !== 1'b0) begin miscompares++; $display("FAIL mid_phi2: got %b, required 0", phi2); end
        vectors++; if (rdb !== 1'b1 || wrb !== 1'b1) begin miscompares++; $display("FAIL mid_strobes: rdb=%b wrb=%b, required 1 1", rdb, wrb); end
        vectors++; if (ba !== 8'h00) begin miscompares++; $display("FAIL mid_ba: got %h, required 00", ba); end
        @(negedge sysclk);
        resetb = 1'b1;
        wait_rise(n);
        vectors++; if (n != 4) begin miscompares++; $display("FAIL mid_rerise: got %0d, required 4", n); end
        wait_fall();
    endtask

`ifdef CSC_EXT_WAIT_EN
    task automatic test_ext_wait();
        int n;
        int hi;
        db = 8'h00; rwb = 1'b1; vda = 1'b1; vpa = 1'b0; rom_sel = 1'b0; io_sel = 1'b1; extwaitb = 1'b0;
        wait_rise(n);
        hi = 0;
        while (phi2 === 1'b1 && hi < 64) begin
            hi++;
            if (hi == 14) extwaitb = 1'b1;
            @(negedge sysclk);
        end
        vectors++; if (hi != 14) begin miscompares++; $display("FAIL ext_high: got %0d, required 14", hi); end
        vectors++; if (cycle_end !== 1'b1) begin miscompares++; $display("FAIL ext_cycle_end: got %b, required 1", cycle_end); end
        vectors++; if (bus_timeout !== 1'b0) begin miscompares++; $display("FAIL ext_no_timeout: got %b, required 0", bus_timeout); end
        extwaitb = 1'b0;
        wait_rise(n);
        hi = 0;
        while (phi2 === 1'b1 && hi < 64) begin
            hi++;
            @(negedge sysclk);
        end
        vectors++; if (hi != 23) begin miscompares++; $display("FAIL ext_timeout_high: got %0d, required 23", hi); end
        vectors++; if (bus_timeout !== 1'b1) begin miscompares++; $display("FAIL ext_timeout_flag: got %b, required 1", bus_timeout); end
        extwaitb = 1'b1;
        run_cycle(8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++; if (bus_timeout !== 1'b1) begin miscompares++; $display("FAIL ext_timeout_sticky: got %b, required 1", bus_timeout); end
        resetb = 1'b0;
        @(negedge sysclk);
        vectors++; if (bus_timeout !== 1'b0) begin miscompares++; $display("FAIL ext_timeout_reset: got %b, required 0", bus_timeout); end
        resetb = 1'b1;
        wait_rise(n);
        wait_fall();
    endtask
`endif

    initial begin : main
        test_reset();
        test_ram_read();
        test_wait_states();
        test_invalid_cycle();
        test_back_to_back();
        test_reset_mid_cycle();
`ifdef CSC_EXT_WAIT_EN
        test_ext_wait();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
